raymarch_scheduler: RTL and testbench

// - Sequences one frame at a time across NUM_CORES parallel raymarcher cores: issues pixel jobs in raster order, collects results, writes them to the frame buffer port A.
// - Sits between the frame timer/control logic and the frame buffer.
// - Replaces the single-core pixel_done raster loop.
// - Frame barrier: a new frame starts only after every pixel of the current frame is written, so frame_count_out is constant for all jobs of a frame.

---
 rtl/raymarch_pkg.sv | 23 ++
 rtl/raymarch_scheduler_arbiter.sv | 43 ++++
 rtl/raymarch_scheduler.sv | 192 +++++++++++++++++++
 tb/tb_raymarch_scheduler.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/raymarch_pkg.sv
// Shared types and helpers for the raymarch frame scheduler.
//   sched_state_t : scheduler FSM states
//   rgb_t         : packed {r,g,b} pixel colour
//   pix_addr      : linear frame-buffer address from (x, y) and line width
package raymarch_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DISPATCH = 2'd1,
        DRAIN    = 2'd2,
        FDONE    = 2'd3
    } sched_state_t;

    typedef logic [23:0] rgb_t;

    // Callers truncate the result to their own address width.
    function automatic logic [31:0] pix_addr(input logic [31:0] x,
                                             input logic [31:0] y,
                                             input logic [31:0] width);
        return x + width * y;
    endfunction

endpackage

// File: rtl/raymarch_scheduler_arbiter.sv
// Round-robin arbiter: one-hot grant among N requesters.
//   clk_in, rst_in : clock, synchronous active-high reset
//   req_i [N]      : request vector
//   grant_o [N]    : one-hot grant (all zero when no request)
// The search starts at the priority pointer; after any grant the pointer
// moves to the index just above the winner.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic [N-1:0] req_i,
    output logic [N-1:0] grant_o
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;

    always_comb begin
        int idx;
        grant_o = '0;
        ptr_d   = ptr_q;
        idx     = 0;
        // Walk from the farthest offset down to the pointer itself so the
        // last hit written (closest to the pointer) wins.
        for (int off = N - 1; off >= 0; off--) begin
            idx = int'(ptr_q) + off;
            if (idx >= N) idx = idx - N;
            if (req_i[idx]) begin
                grant_o      = '0;
                grant_o[idx] = 1'b1;
                ptr_d        = (idx == N - 1) ? '0 : PW'(idx + 1);
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end

endmodule

// File: rtl/raymarch_scheduler.sv
// Frame scheduler for NUM_CORES parallel raymarcher cores.
// Issues pixel jobs in raster order to the lowest-index idle core, collects
// finished results round-robin, writes them to frame-buffer port A, and only
// starts the next frame once every pixel of the current one is written.
//   clk_in, rst_in            : clock, synchronous active-high reset
//   run_in                    : keep rendering frames while high
//   job_x_out/job_y_out       : coordinates of the job being issued
//   core_start_out            : one-hot start pulse per core
//   res_valid/x/y/rgb_in      : per-core finished result (level until acked)
//   res_ack_out               : one-hot result acknowledge
//   fb_we/addr/data_out       : registered frame-buffer write
//   frame_count_out           : completed frames
//   frame_done_out            : pulse when a frame is fully written
//   busy_out                  : high in any state but IDLE
module raymarch_scheduler
    import raymarch_pkg::*;
#(
    parameter int WIDTH     = 1280,
    parameter int HEIGHT    = 720,
    parameter int NUM_CORES = 4,
    localparam int XW = $clog2(WIDTH),
    localparam int YW = $clog2(HEIGHT),
    localparam int AW = $clog2(WIDTH * HEIGHT)
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    run_in,
    output logic [XW-1:0]           job_x_out,
    output logic [YW-1:0]           job_y_out,
    output logic [NUM_CORES-1:0]    core_start_out,
    input  logic [NUM_CORES-1:0]    res_valid_in,
    input  logic [NUM_CORES*XW-1:0] res_x_in,
    input  logic [NUM_CORES*YW-1:0] res_y_in,
    input  logic [NUM_CORES*24-1:0] res_rgb_in,
    output logic [NUM_CORES-1:0]    res_ack_out,
    output logic                    fb_we_out,
    output logic [AW-1:0]           fb_addr_out,
    output logic [23:0]             fb_data_out,
    output logic [31:0]             frame_count_out,
    output logic                    frame_done_out,
    output logic                    busy_out
);
    localparam int OW = $clog2(NUM_CORES + 1);

    sched_state_t state_q, state_d;
    logic [XW-1:0]        x_q, x_d;
    logic [YW-1:0]        y_q, y_d;
    logic [NUM_CORES-1:0] idle_q, idle_d;
    logic [OW-1:0]        outst_q, outst_d;
    logic [31:0]          fc_q, fc_d;
    logic                 fb_we_q;
    logic [AW-1:0]        fb_addr_q;
    rgb_t                 fb_data_q;

    logic [NUM_CORES-1:0] grant;
    logic [NUM_CORES-1:0] lowest_idle;
    logic                 issue;
    logic [XW-1:0]        res_x   [NUM_CORES];
    logic [YW-1:0]        res_y   [NUM_CORES];
    rgb_t                 res_rgb [NUM_CORES];
    logic [XW-1:0]        sel_x;
    logic [YW-1:0]        sel_y;
    rgb_t                 sel_rgb;

    for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_unpack
        assign res_x[gi]   = res_x_in[gi*XW +: XW];
        assign res_y[gi]   = res_y_in[gi*YW +: YW];
        assign res_rgb[gi] = res_rgb_in[gi*24 +: 24];
    end

    rr_arbiter #(.N(NUM_CORES)) u_arb (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .req_i   (res_valid_in),
        .grant_o (grant)
    );

    // Lowest-index idle core as a one-hot vector (zero when all are busy).
    always_comb begin
        lowest_idle = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (idle_q[i]) begin
                lowest_idle    = '0;
                lowest_idle[i] = 1'b1;
            end
        end
    end

    // Grant is one-hot, so an AND-OR select is enough.
    always_comb begin
        sel_x   = '0;
        sel_y   = '0;
        sel_rgb = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (grant[i]) begin
                sel_x   = res_x[i];
                sel_y   = res_y[i];
                sel_rgb = res_rgb[i];
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        x_d            = x_q;
        y_d            = y_q;
        fc_d           = fc_q;
        core_start_out = '0;
        frame_done_out = 1'b0;
        issue          = 1'b0;

        case (state_q)
            IDLE: begin
                if (run_in) state_d = DISPATCH;
            end
            DISPATCH: begin
                if (|idle_q) begin
                    core_start_out = lowest_idle;
                    issue          = 1'b1;
                    if (x_q == XW'(WIDTH - 1)) begin
                        x_d = '0;
                        if (y_q == YW'(HEIGHT - 1)) begin
                            y_d     = '0;
                            state_d = DRAIN;
                        end else begin
                            y_d = y_q + YW'(1);
                        end
                    end else begin
                        x_d = x_q + XW'(1);
                    end
                end
            end
            DRAIN: begin
                // Wait for the last result to be acked and its write to retire.
                if (outst_q == '0 && !fb_we_q) state_d = FDONE;
            end
            FDONE: begin
                frame_done_out = 1'b1;
                fc_d           = fc_q + 32'd1;
                x_d            = '0;
                y_d            = '0;
                state_d        = run_in ? DISPATCH : IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A granted core is busy, so it can never be the one being started.
        idle_d = (idle_q | grant) & ~core_start_out;

        case ({issue, |grant})
            2'b10:   outst_d = outst_q + OW'(1);
            2'b01:   outst_d = outst_q - OW'(1);
            default: outst_d = outst_q;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q   <= IDLE;
            x_q       <= '0;
            y_q       <= '0;
            idle_q    <= '1;
            outst_q   <= '0;
            fc_q      <= '0;
            fb_we_q   <= 1'b0;
            fb_addr_q <= '0;
            fb_data_q <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            idle_q  <= idle_d;
            outst_q <= outst_d;
            fc_q    <= fc_d;
            fb_we_q <= |grant;
            if (|grant) begin
                fb_addr_q <= AW'(pix_addr(32'(sel_x), 32'(sel_y), 32'(WIDTH)));
                fb_data_q <= sel_rgb;
            end
        end
    end

    assign res_ack_out     = grant;
    assign job_x_out       = x_q;
    assign job_y_out       = y_q;
    assign fb_we_out       = fb_we_q;
    assign fb_addr_out     = fb_addr_q;
    assign fb_data_out     = fb_data_q;
    assign frame_count_out = fc_q;
    assign busy_out        = (state_q != IDLE);

endmodule

// File: tb/tb_raymarch_scheduler.sv
// Randomized bench for raymarch_scheduler on a 4x2 frame with two behavioural
// fixed-latency cores. The reference model tracks jobs, core occupancy and the
// round-robin pointer as plain counters and arrays.
module tb_raymarch_scheduler;
    localparam int W    = 4;
    localparam int H    = 2;
    localparam int N    = 2;
    localparam int XW   = 2;
    localparam int YW   = 1;
    localparam int AW   = 3;
    localparam int NPIX = W * H;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst, run;
    logic [N-1:0]    res_valid;
    logic [N*XW-1:0] res_x;
    logic [N*YW-1:0] res_y;
    logic [N*24-1:0] res_rgb;
    logic [XW-1:0]   job_x;
    logic [YW-1:0]   job_y;
    logic [N-1:0]    core_start, res_ack;
    logic            fb_we, frame_done, busy;
    logic [AW-1:0]   fb_addr;
    logic [23:0]     fb_data;
    logic [31:0]     frame_count;

    raymarch_scheduler #(.WIDTH(W), .HEIGHT(H), .NUM_CORES(N)) dut (
        .clk_in          (clk),
        .rst_in          (rst),
        .run_in          (run),
        .job_x_out       (job_x),
        .job_y_out       (job_y),
        .core_start_out  (core_start),
        .res_valid_in    (res_valid),
        .res_x_in        (res_x),
        .res_y_in        (res_y),
        .res_rgb_in      (res_rgb),
        .res_ack_out     (res_ack),
        .fb_we_out       (fb_we),
        .fb_addr_out     (fb_addr),
        .fb_data_out     (fb_data),
        .frame_count_out (frame_count),
        .frame_done_out  (frame_done),
        .busy_out        (busy)
    );

    int total = 0;
    int bad   = 0;

    // Behavioural cores and scoreboard.
    bit          m_busy  [N];
    bit          m_valid [N];
    int          m_rem   [N];
    int          m_lat   [N];
    int          m_x     [N];
    int          m_y     [N];
    logic [23:0] m_rgb   [N];
    bit          written [NPIX];
    int          rr_ptr, issued, wr_cnt, frames, since_full;
    bit          exp_we, color_xy;
    int          exp_addr;
    logic [23:0] exp_data;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < N; i++) begin
            m_busy[i] = 0; m_valid[i] = 0; m_rem[i] = 0;
            m_x[i] = 0; m_y[i] = 0; m_rgb[i] = '0;
        end
        for (int p = 0; p < NPIX; p++) written[p] = 0;
        rr_ptr = 0; issued = 0; wr_cnt = 0; frames = 0; since_full = 0;
        exp_we = 0; exp_addr = 0; exp_data = '0;
    endtask

    task automatic drive_cores();
        for (int i = 0; i < N; i++) begin
            res_valid[i]          = m_valid[i];
            res_x[i*XW +: XW]     = XW'(m_x[i]);
            res_y[i*YW +: YW]     = YW'(m_y[i]);
            res_rgb[i*24 +: 24]   = m_rgb[i];
        end
    endtask

    // One clock: check outputs at the falling edge, advance the model, then
    // drive the cores' new outputs just after the rising edge.
    task automatic step();
        int g, low, idx;
        logic [N-1:0] exp_ack, exp_start;
        @(negedge clk);
        check("frame_count", frame_count, frames);

        if (exp_we) begin
            check("fb_we", fb_we, 1);
            check("fb_addr", fb_addr, exp_addr);
            check("fb_data", fb_data, exp_data);
            check("addr_once", written[exp_addr], 0);
            written[exp_addr] = 1;
            wr_cnt++;
        end else begin
            check("fb_we_quiet", fb_we, 0);
        end
        exp_we = 0;

        g = -1;
        for (int off = 0; off < N; off++) begin
            idx = (rr_ptr + off) % N;
            if (m_valid[idx] && g < 0) g = idx;
        end
        exp_ack = (g < 0) ? '0 : N'(1 << g);
        check("res_ack", res_ack, exp_ack);

        low = -1;
        for (int i = N - 1; i >= 0; i--) if (!m_busy[i]) low = i;
        exp_start = (low < 0) ? '0 : N'(1 << low);
        if (core_start != '0) begin
            check("start_in_frame", issued < NPIX, 1);
            check("start_core", core_start, exp_start);
            check("job_x", job_x, issued % W);
            check("job_y", job_y, issued / W);
        end else if (issued > 0 && issued < NPIX && low >= 0) begin
            check("no_stall", core_start, exp_start);
        end

        if (frame_done) begin
            check("done_writes", wr_cnt, NPIX);
            check("done_issued", issued, NPIX);
            frames++;
            issued = 0; wr_cnt = 0; since_full = 0;
            for (int p = 0; p < NPIX; p++) written[p] = 0;
        end else if (wr_cnt == NPIX) begin
            since_full++;
            if (since_full == 5) check("done_late", frame_done, 1);
        end

        // Model updates: core progress, new job, acknowledged result.
        for (int i = 0; i < N; i++) begin
            if (m_busy[i] && !m_valid[i]) begin
                m_rem[i]--;
                if (m_rem[i] <= 0) m_valid[i] = 1;
            end
        end
        if (core_start != '0 && low >= 0 && core_start == exp_start) begin
            m_busy[low] = 1;
            m_rem[low]  = m_lat[low];
            m_x[low]    = issued % W;
            m_y[low]    = issued / W;
            m_rgb[low]  = color_xy ? 24'(m_x[low] + m_y[low]) : 24'($urandom);
            issued++;
        end
        if (g >= 0) begin
            exp_we   = 1;
            exp_addr = m_x[g] + W * m_y[g];
            exp_data = m_rgb[g];
            m_valid[g] = 0;
            m_busy[g]  = 0;
            rr_ptr     = (g + 1) % N;
        end
        @(posedge clk);
        #1;
        drive_cores();
    endtask

    task automatic do_reset();
        run = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_model();
        drive_cores();
        @(negedge clk);
        check("rst_start", core_start, 0);
        check("rst_job_x", job_x, 0);
        check("rst_job_y", job_y, 0);
        check("rst_ack", res_ack, 0);
        check("rst_fb_we", fb_we, 0);
        check("rst_fb_addr", fb_addr, 0);
        check("rst_fb_data", fb_data, 0);
        check("rst_count", frame_count, 0);
        check("rst_done", frame_done, 0);
        check("rst_busy", busy, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic run_frames(input int target, input bit drop);
        int budget;
        budget = 0;
        run = 1'b1;
        while (frames < target && budget < 1000 * target) begin
            step();
            budget++;
            if (drop && issued >= 1) run = 1'b0;
        end
        check("frames_reached", frames, target);
        $display("run_frames target=%0d drop=%0d lat=%0d/%0d cycles=%0d frame_count=%0d",
                 target, drop, m_lat[0], m_lat[1], budget, frame_count);
        if (drop) begin
            for (int k = 0; k < 10; k++) begin
                step();
                check("idle_no_start", core_start, 0);
                check("idle_busy", busy, 0);
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        run = 1'b0;
        color_xy = 1'b1;
        m_lat[0] = 3;
        m_lat[1] = 3;
        clear_model();
        drive_cores();
        do_reset();

        // Reset in the middle of dispatch, then a full frame from (0,0).
        run = 1'b1;
        repeat (4) step();
        do_reset();
        run_frames(1, 0);
        do_reset();

        // Equal finish cycle for both cores: collisions on the arbiter.
        m_lat[0] = 4; m_lat[1] = 3;
        run_frames(1, 0);
        do_reset();

        // Slow core 1 holds the frame in drain.
        color_xy = 1'b0;
        m_lat[0] = 2; m_lat[1] = 20;
        run_frames(1, 0);
        do_reset();

        // run dropped after the first job.
        m_lat[0] = 3; m_lat[1] = 3;
        run_frames(1, 1);
        do_reset();

        // Back-to-back frames with random latencies.
        for (int r = 0; r < 4; r++) begin
            m_lat[0] = int'($urandom_range(1, 8));
            m_lat[1] = int'($urandom_range(1, 8));
            run_frames(3, 0);
            do_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
